// File: rtl/sargantana_icache_ctrl.sv
// Instruction-cache lookup/refill sequencer: tag-compare enable, victim pick, fill write, replay.
// Define ICACHE_PERF_CNT_EN to add saturating hit/miss counters (hit_cnt_o, miss_cnt_o).
module sargantana_icache_ctrl #(
  parameter int unsigned N_WAY     = 4,
  parameter int unsigned IDX_WIDTH = 6,
  parameter int unsigned CNT_WIDTH = 32
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       req_valid_i,
  output logic                       req_ready_o,
  input  logic [IDX_WIDTH-1:0]       req_idx_i,
  input  logic                       req_kill_i,
  input  logic                       flush_i,
  input  logic [N_WAY-1:0]           cline_hit_i,
  input  logic [N_WAY-1:0]           way_valid_bits_i,
  output logic                       cmp_enable_o,
  output logic                       array_rd_o,
  output logic [IDX_WIDTH-1:0]       array_idx_o,
  output logic                       ifill_req_valid_o,
  input  logic                       ifill_req_ready_i,
  input  logic                       ifill_resp_valid_i,
  output logic                       fill_we_o,
  output logic [$clog2(N_WAY)-1:0]   fill_way_o,
  output logic                       valid_clear_o,
  output logic                       resp_valid_o,
`ifdef ICACHE_PERF_CNT_EN
  output logic [CNT_WIDTH-1:0]       hit_cnt_o,
  output logic [CNT_WIDTH-1:0]       miss_cnt_o,
`endif
  output logic                       busy_o
);

  localparam int unsigned WAY_W = $clog2(N_WAY);

  if (N_WAY < 2 || (N_WAY & (N_WAY - 1)) != 0 || CNT_WIDTH < 1) begin : g_bad_cfg
    $error("sargantana_icache_ctrl: N_WAY must be a power of two >= 2 and CNT_WIDTH >= 1");
  end

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    MISS_REQ,
    WAIT_FILL,
    REPLAY,
    FLUSH
  } state_e;

  state_e               state_q, state_d;
  logic [IDX_WIDTH-1:0] idx_q;
  logic [WAY_W-1:0]     victim_q;
  logic [WAY_W-1:0]     rr_ptr_q;
  logic                 use_rr_q;
  logic                 kill_pend_q;
  logic                 flush_pend_q;

  logic                 free_found;
  logic [WAY_W-1:0]     free_way;
  logic                 accept;

  assign accept = (state_q == IDLE) && !flush_pend_q && !flush_i && req_valid_i;

  // Lowest-index invalid way; round-robin pointer only when the set is full.
  always_comb begin
    free_found = 1'b0;
    free_way   = '0;
    for (int unsigned w = 0; w < N_WAY; w++) begin
      if (!free_found && !way_valid_bits_i[w]) begin
        free_found = 1'b1;
        free_way   = WAY_W'(w);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      victim_q     <= '0;
      rr_ptr_q     <= '0;
      use_rr_q     <= 1'b0;
      kill_pend_q  <= 1'b0;
      flush_pend_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) idx_q <= req_idx_i;
      if (state_q == LOOKUP && state_d == MISS_REQ) begin
        victim_q <= free_found ? free_way : rr_ptr_q;
        use_rr_q <= !free_found;
      end
      // A kill racing the L2 handshake still owns a response, so it is deferred like a WAIT_FILL kill.
      if (state_q == WAIT_FILL && ifill_resp_valid_i) begin
        kill_pend_q <= 1'b0;
        if (use_rr_q) rr_ptr_q <= rr_ptr_q + 1'b1;
      end else if (req_kill_i && (state_q == WAIT_FILL ||
                                  (state_q == MISS_REQ && ifill_req_ready_i))) begin
        kill_pend_q <= 1'b1;
      end
      if (state_q == IDLE && state_d == FLUSH) flush_pend_q <= 1'b0;
      else if (flush_i && state_q != IDLE)     flush_pend_q <= 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (flush_pend_q || flush_i) state_d = FLUSH;
        else if (req_valid_i)        state_d = LOOKUP;
      end
      LOOKUP: begin
        if (req_kill_i || (|cline_hit_i)) state_d = IDLE;
        else                              state_d = MISS_REQ;
      end
      MISS_REQ: begin
        if (ifill_req_ready_i) state_d = WAIT_FILL;
        else if (req_kill_i)   state_d = IDLE;
      end
      WAIT_FILL: begin
        if (ifill_resp_valid_i) state_d = (kill_pend_q || req_kill_i) ? IDLE : REPLAY;
      end
      REPLAY:  state_d = LOOKUP;
      FLUSH:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready_o       = 1'b0;
    cmp_enable_o      = 1'b0;
    array_rd_o        = 1'b0;
    array_idx_o       = idx_q;
    ifill_req_valid_o = 1'b0;
    fill_we_o         = 1'b0;
    fill_way_o        = '0;
    valid_clear_o     = 1'b0;
    resp_valid_o      = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready_o = !flush_pend_q && !flush_i;
        if (accept) begin
          array_rd_o  = 1'b1;
          array_idx_o = req_idx_i;
        end
      end
      LOOKUP: begin
        cmp_enable_o = 1'b1;
        resp_valid_o = (|cline_hit_i) && !req_kill_i;
      end
      MISS_REQ: ifill_req_valid_o = 1'b1;
      WAIT_FILL: begin
        if (ifill_resp_valid_i) begin
          fill_we_o  = 1'b1;
          fill_way_o = victim_q;
        end
      end
      REPLAY:  array_rd_o = 1'b1;
      FLUSH:   valid_clear_o = 1'b1;
      default: ;
    endcase
  end

  assign busy_o = (state_q != IDLE);

`ifdef ICACHE_PERF_CNT_EN
  logic replay_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      replay_q   <= 1'b0;
      hit_cnt_o  <= '0;
      miss_cnt_o <= '0;
    end else begin
      if (state_q == REPLAY)  replay_q <= 1'b1;
      else if (accept)        replay_q <= 1'b0;
      if (resp_valid_o && !replay_q && hit_cnt_o != '1)
        hit_cnt_o <= hit_cnt_o + CNT_WIDTH'(1);
      if (state_q == LOOKUP && state_d == MISS_REQ && miss_cnt_o != '1)
        miss_cnt_o <= miss_cnt_o + CNT_WIDTH'(1);
    end
  end
`endif

endmodule

// File: tb/tb_sargantana_icache_ctrl.sv
// Scoreboard bench for sargantana_icache_ctrl: stimulus queues timed expected events, a monitor checks them.
module tb_sargantana_icache_ctrl;
  localparam int unsigned N_WAY     = 4;
  localparam int unsigned IDX_WIDTH = 6;
  localparam int unsigned CNT_WIDTH = 32;

  logic                 clk, rst;
  logic                 req_valid, req_ready, req_kill, flush;
  logic [IDX_WIDTH-1:0] req_idx;
  logic [N_WAY-1:0]     cline_hit, way_valid;
  logic                 cmp_enable, array_rd;
  logic [IDX_WIDTH-1:0] array_idx;
  logic                 ifill_req_valid, ifill_req_ready, ifill_resp_valid;
  logic                 fill_we, valid_clear, resp_valid, busy;
  logic [$clog2(N_WAY)-1:0] fill_way;
`ifdef ICACHE_PERF_CNT_EN
  logic [CNT_WIDTH-1:0] hit_cnt, miss_cnt;
`endif

  sargantana_icache_ctrl #(.N_WAY(N_WAY), .IDX_WIDTH(IDX_WIDTH), .CNT_WIDTH(CNT_WIDTH)) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_idx_i(req_idx),
    .req_kill_i(req_kill), .flush_i(flush),
    .cline_hit_i(cline_hit), .way_valid_bits_i(way_valid),
    .cmp_enable_o(cmp_enable), .array_rd_o(array_rd), .array_idx_o(array_idx),
    .ifill_req_valid_o(ifill_req_valid), .ifill_req_ready_i(ifill_req_ready),
    .ifill_resp_valid_i(ifill_resp_valid),
    .fill_we_o(fill_we), .fill_way_o(fill_way), .valid_clear_o(valid_clear),
    .resp_valid_o(resp_valid),
`ifdef ICACHE_PERF_CNT_EN
    .hit_cnt_o(hit_cnt), .miss_cnt_o(miss_cnt),
`endif
    .busy_o(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int cyc;
    int way;
    int idx;
  } ev_t;

  ev_t q_resp[$], q_req[$], q_fill[$], q_clr[$];
  int  checks = 0, failures = 0, cyc = 0;
  int  exp_hits = 0, exp_misses = 0;
  ev_t me;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic ev_t mk(input int c, input int w, input int i);
    ev_t e;
    e.cyc = c; e.way = w; e.idx = i;
    return e;
  endfunction

  task automatic chk(input string name, input int act, input int want);
    checks++;
    if (act != want) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, want, cyc);
    end
  endtask

  // Every active cycle of an observed output must match a queued expectation.
  always @(negedge clk) begin
    if (resp_valid) begin
      if (q_resp.size() == 0) chk("resp_unexpected", cyc, -1);
      else begin me = q_resp.pop_front(); chk("resp_cycle", cyc, me.cyc); end
    end
    if (ifill_req_valid) begin
      if (q_req.size() == 0) chk("ifill_req_unexpected", cyc, -1);
      else begin me = q_req.pop_front(); chk("ifill_req_cycle", cyc, me.cyc); end
    end
    if (valid_clear) begin
      if (q_clr.size() == 0) chk("valid_clear_unexpected", cyc, -1);
      else begin me = q_clr.pop_front(); chk("valid_clear_cycle", cyc, me.cyc); end
    end
    if (fill_we) begin
      if (q_fill.size() == 0) chk("fill_unexpected", cyc, -1);
      else begin
        me = q_fill.pop_front();
        chk("fill_cycle", cyc, me.cyc);
        chk("fill_way", int'(fill_way), me.way);
        chk("fill_idx", int'(array_idx), me.idx);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_hit(input int idx, input logic [N_WAY-1:0] hv);
    int c;
    c = cyc;
    q_resp.push_back(mk(c + 1, 0, 0));
    exp_hits++;
    req_valid = 1'b1; req_idx = IDX_WIDTH'(idx);
    step();
    req_valid = 1'b0; cline_hit = hv;
    step();
    cline_hit = '0;
  endtask

  task automatic do_miss(input int idx, input logic [N_WAY-1:0] vb, input int exp_way,
                         input int rdy_delay, input int resp_delay, input bit kill, input bit fl);
    int c, f;
    c = cyc;
    exp_misses++;
    req_valid = 1'b1; req_idx = IDX_WIDTH'(idx);
    step();
    req_valid = 1'b0; cline_hit = '0; way_valid = vb;
    step();
    for (int d = 0; d <= rdy_delay; d++) begin
      q_req.push_back(mk(c + 2 + d, 0, 0));
      ifill_req_ready = (d == rdy_delay);
      step();
    end
    ifill_req_ready = 1'b0;
    req_kill = kill; flush = fl;
    for (int d = 0; d < resp_delay; d++) begin
      step();
      req_kill = 1'b0; flush = 1'b0;
    end
    f = cyc;
    q_fill.push_back(mk(f, exp_way, idx));
    ifill_resp_valid = 1'b1;
    step();
    ifill_resp_valid = 1'b0; req_kill = 1'b0; flush = 1'b0;
    if (kill) begin
      chk("kill_wait_idle_busy", int'(busy), 0);
    end else begin
      step();
      cline_hit = N_WAY'(1) << exp_way;
      q_resp.push_back(mk(f + 2, 0, 0));
      step();
      cline_hit = '0;
    end
  endtask

  initial begin
    int c;
    rst = 1'b1; req_valid = 1'b0; req_idx = '0; req_kill = 1'b0; flush = 1'b0;
    cline_hit = '0; way_valid = '0; ifill_req_ready = 1'b0; ifill_resp_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_ready", int'(req_ready), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_resp_valid", int'(resp_valid), 0);
    chk("rst_cmp_enable", int'(cmp_enable), 0);
    chk("rst_array_rd", int'(array_rd), 0);
    chk("rst_array_idx", int'(array_idx), 0);
    chk("rst_fill_we", int'(fill_we), 0);
    chk("rst_valid_clear", int'(valid_clear), 0);
    chk("rst_ifill_req", int'(ifill_req_valid), 0);
    rst = 1'b0;
    step();

    do_hit(5, 4'b0100);
    do_miss(9, 4'b1101, 1, 2, 1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) do_miss(10 + i, 4'b1111, i % 4, 0, 1, 1'b0, 1'b0);
    do_miss(20, 4'b1111, 1, 0, 1, 1'b1, 1'b0);

    // Flush during WAIT_FILL: takes effect on the IDLE cycle after the replayed hit.
    do_miss(21, 4'b1111, 2, 1, 1, 1'b0, 1'b1);
    c = cyc;
    req_valid = 1'b1; req_idx = 6'd22;
    #1;
    chk("pend_flush_req_ready", int'(req_ready), 0);
    q_clr.push_back(mk(c + 1, 0, 0));
    step();
    req_valid = 1'b0;
    step();
    chk("pend_flush_idle", int'(busy), 0);

    // Kill and hit together in LOOKUP: kill wins.
    req_valid = 1'b1; req_idx = 6'd3;
    step();
    req_valid = 1'b0; cline_hit = 4'b0100; req_kill = 1'b1;
    step();
    cline_hit = '0; req_kill = 1'b0;
    chk("kill_hit_idle", int'(busy), 0);

    // Flush together with a request in IDLE.
    c = cyc;
    flush = 1'b1; req_valid = 1'b1; req_idx = 6'd7;
    #1;
    chk("flush_req_ready", int'(req_ready), 0);
    q_clr.push_back(mk(c + 1, 0, 0));
    step();
    flush = 1'b0; req_valid = 1'b0;
    step();
    chk("flush_idle_busy", int'(busy), 0);

    // Kill before the L2 handshake drops the refill.
    c = cyc;
    exp_misses++;
    req_valid = 1'b1; req_idx = 6'd40;
    step();
    req_valid = 1'b0; way_valid = 4'b1111;
    step();
    q_req.push_back(mk(c + 2, 0, 0));
    req_kill = 1'b1;
    step();
    req_kill = 1'b0;
    chk("kill_missreq_idle", int'(busy), 0);

    // Reset in WAIT_FILL, then a stray response while IDLE.
    c = cyc;
    req_valid = 1'b1; req_idx = 6'd50;
    step();
    req_valid = 1'b0; way_valid = 4'b1111;
    step();
    q_req.push_back(mk(c + 2, 0, 0));
    ifill_req_ready = 1'b1;
    step();
    ifill_req_ready = 1'b0;
    chk("refill_busy", int'(busy), 1);
    rst = 1'b1;
    #1;
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_req_ready", int'(req_ready), 1);
    exp_hits = 0; exp_misses = 0;
    step();
    rst = 1'b0; ifill_resp_valid = 1'b1;
    step();
    ifill_resp_valid = 1'b0;
    chk("stray_resp_idle", int'(busy), 0);

    do_hit(33, 4'b0001);
    do_miss(30, 4'b1111, 0, 0, 0, 1'b0, 1'b0);
    do_hit(34, 4'b1000);
    do_miss(31, 4'b1111, 1, 0, 1, 1'b0, 1'b0);
    do_hit(35, 4'b0010);
`ifdef ICACHE_PERF_CNT_EN
    chk("hit_cnt", int'(hit_cnt), exp_hits);
    chk("miss_cnt", int'(miss_cnt), exp_misses);
`endif
    repeat (3) step();

    chk("pending_resp", q_resp.size(), 0);
    chk("pending_ifill_req", q_req.size(), 0);
    chk("pending_fill", q_fill.size(), 0);
    chk("pending_valid_clear", q_clr.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
